// File: rtl/mem0_stage.sv
// First memory pipeline stage: holds the execute result, issues one data-SRAM
// request per load/store over a req/addr_ok handshake and forwards the mem1 bus.
module mem0_stage #(
  parameter int EX2MEM0_W   = 108,
  parameter int MEM02MEM1_W = 77
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [EX2MEM0_W-1:0]   ex2mem0_bus_i,
  input  logic                   ctl_ex_over_i,
  output logic                   ctl_mem0_allowin_o,
  input  logic                   ctl_mem1_allowin_i,
  output logic [MEM02MEM1_W-1:0] mem0_2_mem1_bus_o,
  output logic                   ctl_mem0_over_o,
  output logic [4:0]             ctl_mem0_dest_o,
  output logic [31:0]            ctl_mem0_pc_o,
  output logic                   data_req_o,
  output logic                   data_wr_o,
  output logic [1:0]             data_size_o,
  output logic [31:0]            data_addr_o,
  output logic [3:0]             data_wstrb_o,
  output logic [31:0]            data_wdata_o,
  input  logic                   data_addr_ok_i,
  output logic                   ale_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               r_state;
  logic                 r_valid;
  logic [EX2MEM0_W-1:0] r_bus;

  logic [5:0]  w_mem_ctl;
  logic [31:0] w_st_data;
  logic [31:0] w_result;
  logic [4:0]  w_rd_addr;
  logic        w_rd_we;
  logic [31:0] w_pc;
  logic        w_load;
  logic        w_store;
  logic        w_is_mem;
  logic [1:0]  w_size;
  logic        w_ale;
  logic        w_req;
  logic        w_hs;
  logic        w_over;
  logic        w_allowin;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_unused;

  assign w_mem_ctl = r_bus[107:102];
  assign w_st_data = r_bus[101:70];
  assign w_result  = r_bus[69:38];
  assign w_rd_addr = r_bus[37:33];
  assign w_rd_we   = r_bus[32];
  assign w_pc      = r_bus[31:0];
  assign w_unused  = w_mem_ctl[0];

  // A store bit wins over a load bit; size 11 is folded into word.
  assign w_store  = w_mem_ctl[4];
  assign w_load   = w_mem_ctl[5] & ~w_mem_ctl[4];
  assign w_is_mem = w_mem_ctl[5] | w_mem_ctl[4];
  assign w_size   = w_mem_ctl[3] ? 2'b10 : w_mem_ctl[3:2];

  assign w_ale = r_valid & w_is_mem &
                 (((w_size == 2'b01) & w_result[0]) | (w_size[1] & (|w_result[1:0])));

  assign w_req     = r_valid & w_is_mem & ~w_ale & (r_state != S_DONE);
  assign w_hs      = w_req & data_addr_ok_i;
  assign w_over    = r_valid & (~w_is_mem | w_ale | (r_state == S_DONE) | w_hs);
  assign w_allowin = ~r_valid | (w_over & ctl_mem1_allowin_i);

  always_comb begin
    w_wstrb = '0;
    w_wdata = w_st_data;
    case (w_size)
      2'b00: begin
        w_wstrb = 4'b0001 << w_result[1:0];
        w_wdata = {4{w_st_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << {w_result[1], 1'b0};
        w_wdata = {2{w_st_data[15:0]}};
      end
      default: w_wstrb = '1;
    endcase
    if (!w_store) w_wstrb = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      if (w_allowin) r_valid <= ctl_ex_over_i;
      case (r_state)
        S_IDLE: begin
          if (w_req && !data_addr_ok_i)          r_state <= S_WAIT;
          else if (w_hs && !ctl_mem1_allowin_i)  r_state <= S_DONE;
        end
        S_WAIT: begin
          if (data_addr_ok_i) r_state <= ctl_mem1_allowin_i ? S_IDLE : S_DONE;
        end
        S_DONE: begin
          if (ctl_mem1_allowin_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         r_bus <= '0;
    else if (w_allowin && ctl_ex_over_i) r_bus <= ex2mem0_bus_i;
  end

  assign ctl_mem0_allowin_o = w_allowin;
  assign ctl_mem0_over_o    = w_over;
  assign ctl_mem0_dest_o    = w_rd_addr & {5{r_valid}};
  assign ctl_mem0_pc_o      = w_pc;
  assign ale_o              = w_ale;

  assign data_req_o   = w_req;
  assign data_wr_o    = w_store;
  assign data_size_o  = w_size;
  assign data_addr_o  = w_result;
  assign data_wstrb_o = w_wstrb;
  assign data_wdata_o = w_wdata;

  assign mem0_2_mem1_bus_o = {w_load, w_mem_ctl[1], w_size, w_result[1:0], w_ale,
                              w_result, w_rd_addr, w_rd_we & ~w_ale, w_pc};

endmodule

// File: tb/tb_mem0_stage.sv
// Scoreboard bench for mem0_stage: expected mem1-bus words are queued when an
// instruction is driven and checked whenever mem1 takes one.
module tb_mem0_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [107:0] ex_bus = '0;
  logic         ex_over = 1'b0;
  logic         allowin;
  logic         mem1_allowin = 1'b1;
  logic [76:0]  out_bus;
  logic         over;
  logic [4:0]   dest;
  logic [31:0]  pc_o;
  logic         req, wr, ale;
  logic [1:0]   size;
  logic [31:0]  addr, wdata;
  logic [3:0]   wstrb;
  logic         addr_ok = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [76:0] sbq[$];

  always #5 clk = ~clk;

  mem0_stage #(.EX2MEM0_W(108), .MEM02MEM1_W(77)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex2mem0_bus_i(ex_bus), .ctl_ex_over_i(ex_over),
    .ctl_mem0_allowin_o(allowin), .ctl_mem1_allowin_i(mem1_allowin),
    .mem0_2_mem1_bus_o(out_bus), .ctl_mem0_over_o(over),
    .ctl_mem0_dest_o(dest), .ctl_mem0_pc_o(pc_o),
    .data_req_o(req), .data_wr_o(wr), .data_size_o(size),
    .data_addr_o(addr), .data_wstrb_o(wstrb), .data_wdata_o(wdata),
    .data_addr_ok_i(addr_ok), .ale_o(ale)
  );

  function automatic logic [107:0] mk(input logic [5:0] ctl, input logic [31:0] st,
                                      input logic [31:0] res, input logic [4:0] rd,
                                      input logic we, input logic [31:0] pc);
    return {ctl, st, res, rd, we, pc};
  endfunction

  // Reference model of the forwarded bus, written from the field definitions.
  function automatic logic [76:0] exp_bus(input logic [5:0] ctl, input logic [31:0] res,
                                          input logic [4:0] rd, input logic we,
                                          input logic [31:0] pc);
    logic [1:0] sz;
    logic       mis;
    logic       ld;
    sz = ctl[3:2];
    if (sz == 2'b11) sz = 2'b10;
    mis = 1'b0;
    if (ctl[5] || ctl[4]) begin
      if (sz == 2'b01 && res[0] == 1'b1) mis = 1'b1;
      if (sz == 2'b10 && res[1:0] != 2'b00) mis = 1'b1;
    end
    ld = ctl[5] && !ctl[4];
    return {ld, ctl[1], sz, res[1:0], mis, res, rd, (we && !mis), pc};
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] s;
    for (int unsigned l = 0; l < 4; l++) begin
      case (sz)
        2'b00:   s[l] = (l == a);
        2'b01:   s[l] = ((l / 2) == a[1]);
        default: s[l] = 1'b1;
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] st);
    logic [31:0] d;
    for (int unsigned l = 0; l < 4; l++) begin
      case (sz)
        2'b00:   d[8*l +: 8] = st[7:0];
        2'b01:   d[8*l +: 8] = st[8*(l%2) +: 8];
        default: d[8*l +: 8] = st[8*l +: 8];
      endcase
    end
    return d;
  endfunction

  // mem1 side: pop the scoreboard whenever an instruction is handed over.
  always @(negedge clk) begin
    if (rst_n && req && addr_ok) n_acc++;
    if (rst_n && over && mem1_allowin) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL mem1_bus: unexpected instruction %h, none queued", out_bus);
      end else begin
        logic [76:0] e;
        e = sbq.pop_front();
        if (out_bus !== e) begin
          n_err++;
          $display("FAIL mem1_bus: got %h expected %h", out_bus, e);
        end
      end
    end
  end

  // Call at posedge+1 with allowin high; returns at posedge+1 after capture.
  task automatic load_ex(input logic [107:0] b);
    ex_bus  = b;
    ex_over = 1'b1;
    @(posedge clk); #1;
    ex_over = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (req !== 1'b0)     begin n_err++; $display("FAIL rst_req: got %b want 0", req); end
    n_vec++; if (over !== 1'b0)    begin n_err++; $display("FAIL rst_over: got %b want 0", over); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_vec++; if (allowin !== 1'b1) begin n_err++; $display("FAIL rst_allowin: got %b want 1", allowin); end
    n_vec++; if (dest !== 5'd0)    begin n_err++; $display("FAIL rst_dest: got %0d want 0", dest); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    mem1_allowin = 1'b1;
    sbq.push_back(exp_bus(6'b0, 32'h1234, 5'd5, 1'b1, 32'h100));
    load_ex(mk(6'b0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h100));
    #1;
    n_vec++; if (over !== 1'b1)     begin n_err++; $display("FAIL alu_over: got %b want 1", over); end
    n_vec++; if (req !== 1'b0)      begin n_err++; $display("FAIL alu_req: got %b want 0", req); end
    n_vec++; if (dest !== 5'd5)     begin n_err++; $display("FAIL alu_dest: got %0d want 5", dest); end
    n_vec++; if (pc_o !== 32'h100)  begin n_err++; $display("FAIL alu_pc: got %h want 100", pc_o); end
    @(posedge clk); #1;
    n_vec++; if (over !== 1'b0)     begin n_err++; $display("FAIL alu_drain: got %b want 0", over); end
  endtask

  task automatic test_store_byte();
    addr_ok = 1'b1;
    sbq.push_back(exp_bus(6'b010000, 32'h1003, 5'd0, 1'b0, 32'h104));
    load_ex(mk(6'b010000, 32'hAABBCCDD, 32'h1003, 5'd0, 1'b0, 32'h104));
    #1;
    n_vec++; if (req !== 1'b1)            begin n_err++; $display("FAIL sb_req: got %b want 1", req); end
    n_vec++; if (wr !== 1'b1)             begin n_err++; $display("FAIL sb_wr: got %b want 1", wr); end
    n_vec++; if (wstrb !== 4'b1000)       begin n_err++; $display("FAIL sb_wstrb: got %b want 1000", wstrb); end
    n_vec++; if (wdata !== 32'hDDDDDDDD)  begin n_err++; $display("FAIL sb_wdata: got %h want DDDDDDDD", wdata); end
    n_vec++; if (addr !== 32'h1003)       begin n_err++; $display("FAIL sb_addr: got %h want 1003", addr); end
    n_vec++; if (over !== 1'b1)           begin n_err++; $display("FAIL sb_over: got %b want 1", over); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_wait();
    int acc0;
    addr_ok = 1'b0;
    acc0 = n_acc;
    sbq.push_back(exp_bus(6'b101000, 32'h0000_2468, 5'd9, 1'b1, 32'h108));
    load_ex(mk(6'b101000, 32'h0, 32'h0000_2468, 5'd9, 1'b1, 32'h108));
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (req !== 1'b1)           begin n_err++; $display("FAIL lw_req[%0d]: got %b want 1", c, req); end
      n_vec++; if (addr !== 32'h2468)      begin n_err++; $display("FAIL lw_addr[%0d]: got %h want 2468", c, addr); end
      n_vec++; if (allowin !== 1'b0)       begin n_err++; $display("FAIL lw_stall[%0d]: got %b want 0", c, allowin); end
      n_vec++; if (over !== 1'b0)          begin n_err++; $display("FAIL lw_over[%0d]: got %b want 0", c, over); end
      @(posedge clk); #1;
    end
    addr_ok = 1'b1;
    #1;
    n_vec++; if (req !== 1'b1)   begin n_err++; $display("FAIL lw_req4: got %b want 1", req); end
    n_vec++; if (over !== 1'b1)  begin n_err++; $display("FAIL lw_over4: got %b want 1", over); end
    n_vec++; if (wstrb !== 4'b0) begin n_err++; $display("FAIL lw_wstrb: got %b want 0000", wstrb); end
    @(posedge clk); #1;
    addr_ok = 1'b0;
    n_vec++; if (n_acc - acc0 !== 1) begin n_err++; $display("FAIL lw_accepts: got %0d want 1", n_acc - acc0); end
  endtask

  task automatic test_misaligned();
    sbq.push_back(exp_bus(6'b100100, 32'h2001, 5'd7, 1'b1, 32'h10C));
    load_ex(mk(6'b100100, 32'h0, 32'h2001, 5'd7, 1'b1, 32'h10C));
    #1;
    n_vec++; if (ale !== 1'b1)  begin n_err++; $display("FAIL ale_flag: got %b want 1", ale); end
    n_vec++; if (req !== 1'b0)  begin n_err++; $display("FAIL ale_req: got %b want 0", req); end
    n_vec++; if (over !== 1'b1) begin n_err++; $display("FAIL ale_over: got %b want 1", over); end
    @(posedge clk); #1;
  endtask

  task automatic test_done_hold();
    int acc0;
    acc0 = n_acc;
    addr_ok = 1'b1;
    mem1_allowin = 1'b0;
    sbq.push_back(exp_bus(6'b011000, 32'h100, 5'd0, 1'b0, 32'h110));
    load_ex(mk(6'b011000, 32'h12345678, 32'h100, 5'd0, 1'b0, 32'h110));
    #1;
    n_vec++; if (req !== 1'b1)     begin n_err++; $display("FAIL done_req1: got %b want 1", req); end
    n_vec++; if (allowin !== 1'b0) begin n_err++; $display("FAIL done_allow1: got %b want 0", allowin); end
    @(posedge clk); #1;
    n_vec++; if (req !== 1'b0)     begin n_err++; $display("FAIL done_req2: got %b want 0", req); end
    n_vec++; if (over !== 1'b1)    begin n_err++; $display("FAIL done_over2: got %b want 1", over); end
    @(posedge clk); #1;
    mem1_allowin = 1'b1;
    #1;
    n_vec++; if (over !== 1'b1)    begin n_err++; $display("FAIL done_over3: got %b want 1", over); end
    n_vec++; if (allowin !== 1'b1) begin n_err++; $display("FAIL done_allow3: got %b want 1", allowin); end
    @(posedge clk); #1;
    n_vec++; if (over !== 1'b0)    begin n_err++; $display("FAIL done_leave: got %b want 0", over); end
    n_vec++; if (n_acc - acc0 !== 1) begin n_err++; $display("FAIL done_accepts: got %0d want 1", n_acc - acc0); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ctl [5];
    logic [31:0] res [5];
    logic [31:0] st;
    addr_ok = 1'b1;
    mem1_allowin = 1'b1;
    ctl[0] = 6'b000000; res[0] = 32'h0000_0ABC;
    ctl[1] = 6'b010000; res[1] = 32'h0000_2002;
    ctl[2] = 6'b010100; res[2] = 32'h0000_3002;
    ctl[3] = 6'b011100; res[3] = 32'h0000_4000;
    ctl[4] = 6'b100010; res[4] = 32'h0000_5003;
    for (int i = 0; i < 5; i++) begin
      st = $urandom();
      sbq.push_back(exp_bus(ctl[i], res[i], 5'(i + 1), 1'b1, 32'h200 + 32'(4 * i)));
      ex_bus  = mk(ctl[i], st, res[i], 5'(i + 1), 1'b1, 32'h200 + 32'(4 * i));
      ex_over = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (over !== 1'b1) begin n_err++; $display("FAIL b2b_over[%0d]: got %b want 1", i, over); end
      if (ctl[i][4]) begin
        logic [1:0] sz;
        sz = ctl[i][3] ? 2'b10 : ctl[i][3:2];
        n_vec++;
        if (wstrb !== exp_strb(sz, res[i][1:0]) || wdata !== exp_wdata(sz, st)) begin
          n_err++;
          $display("FAIL b2b_store[%0d]: got %b/%h want %b/%h", i, wstrb, wdata,
                   exp_strb(sz, res[i][1:0]), exp_wdata(sz, st));
        end
      end
    end
    ex_over = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    addr_ok = 1'b0;
    mem1_allowin = 1'b1;
    load_ex(mk(6'b101000, 32'h0, 32'h40, 5'd3, 1'b1, 32'h300));
    @(posedge clk); #1;
    n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL rw_req: got %b want 1", req); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (req !== 1'b0)     begin n_err++; $display("FAIL rw_req_drop: got %b want 0", req); end
    n_vec++; if (over !== 1'b0)    begin n_err++; $display("FAIL rw_over_drop: got %b want 0", over); end
    n_vec++; if (dest !== 5'd0)    begin n_err++; $display("FAIL rw_dest_drop: got %0d want 0", dest); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_vec++; if (allowin !== 1'b1) begin n_err++; $display("FAIL rw_allowin: got %b want 1", allowin); end
    @(posedge clk); #1;
    addr_ok = 1'b1;
    sbq.push_back(exp_bus(6'b011000, 32'h44, 5'd0, 1'b0, 32'h304));
    load_ex(mk(6'b011000, 32'h0, 32'h44, 5'd0, 1'b0, 32'h304));
    #1;
    n_vec++; if (req !== 1'b1 || over !== 1'b1) begin
      n_err++; $display("FAIL rw_idle: got req=%b over=%b want 1/1", req, over);
    end
    @(posedge clk); #1;
    addr_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_store_byte();
    test_load_wait();
    test_misaligned();
    test_done_hold();
    test_back_to_back();
    test_reset_in_wait();
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem0_stage.md
Name: mem0_stage

Overview:
- First memory pipeline stage, directly downstream of the execute stage.
- Latches the execute-to-mem0 bus into its stage register, decodes the load/store control, and issues one request per memory instruction on the data-SRAM address channel (req/addr_ok handshake).
- Forwards a mem0-to-mem1 bus, which carries the information mem1 needs to take data_ok, extend loads and write back.
- Non-memory instructions pass through in one cycle.

Parameters:
- EX2MEM0_W, 108, width of the input bus: mem_ctl 6 + st_data 32 + exe_result 32 + rd_addr 5 + rd_we 1 + pc 32.
- MEM02MEM1_W, 77, width of the output bus: load 1, unsigned 1, size 2, addr_lo 2, ale 1, exe_result 32, rd_addr 5, rd_we 1, pc 32.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ex2mem0_bus_i  in  108  execute result bus, fields MSB-first as listed under Parameters.
- ctl_ex_over_i  in  1  execute stage holds a finished instruction.
- ctl_mem0_allowin_o  out  1  mem0 can accept an instruction this cycle.
- ctl_mem1_allowin_i  in  1  mem1 can accept an instruction this cycle.
- mem0_2_mem1_bus_o  out  77  bus to mem1.
- ctl_mem0_over_o  out  1  mem0 instruction is complete and valid toward mem1.
- ctl_mem0_dest_o  out  5  destination register, for hazard detection.
- ctl_mem0_pc_o  out  32  pc of the held instruction.
- data_req_o  out  1  memory request.
- data_wr_o  out  1  1 = store.
- data_size_o  out  2  00 byte, 01 half, 10 word.
- data_addr_o  out  32  byte address (= exe_result).
- data_wstrb_o  out  4  byte enables.
- data_wdata_o  out  32  store data, lane-replicated.
- data_addr_ok_i  in  1  address channel accepted the request.
- ale_o  out  1  misaligned access detected on the held instruction.

Behaviour:
- mem_ctl encoding: [5] load, [4] store, [3:2] size, [1] unsigned-load, [0] reserved and ignored. Size 11 behaves as word. is_mem = load|store; if both bits are set, the access is treated as a store.
- Stage register and valid:
  - valid <= 0 on reset.
  - When ctl_mem0_allowin_o is high, valid <= ctl_ex_over_i.
  - The bus is latched only when ctl_mem0_allowin_o & ctl_ex_over_i.
  - ctl_mem0_allowin_o = ~valid | (ctl_mem0_over_o & ctl_mem1_allowin_i).
- Misalignment:
  - ale = valid & is_mem & ((size==01 & addr[0]) | (size[1] & addr[1:0]!=0)).
  - ale_o = ale.
  - A misaligned instruction never issues data_req_o, completes in one cycle, and forwards ale=1 and rd_we=0 on the bus.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
  - data_req_o = valid & is_mem & ~ale & (state!=DONE).
  - IDLE: if data_req_o & ~data_addr_ok_i, go to WAIT. If the handshake completes (data_req_o & data_addr_ok_i) & ~ctl_mem1_allowin_i, go to DONE. Otherwise stay in IDLE.
  - WAIT: data_req_o stays high and the address, wdata, wstrb, wr and size stay stable (the stage register is frozen). On addr_ok: go to IDLE if ctl_mem1_allowin_i, else go to DONE.
  - DONE: data_req_o is low (no re-issue). Go to IDLE when ctl_mem1_allowin_i.
- ctl_mem0_over_o = valid & (~is_mem | ale | state==DONE | (data_req_o & data_addr_ok_i)).
- Latency: non-memory instructions take 1 cycle. Memory instructions take 1 cycle if addr_ok arrives in the first cycle, else 1 + the number of addr_ok wait cycles.
- Store lanes:
  - byte: wstrb = 0001<<addr[1:0], wdata = {4{st[7:0]}}.
  - half: wstrb = 0011<<{addr[1],1'b0}, wdata = {2{st[15:0]}}.
  - word: wstrb = 1111, wdata = st.
  - Loads drive wstrb = 0000.
  - data_wdata_o and data_wstrb_o are don't-care when data_req_o is low.
- ctl_mem0_dest_o = rd_addr & {5{valid}}.
- ctl_mem0_pc_o = held pc.
- Output bus: {load, unsigned, size, addr[1:0], ale, exe_result, rd_addr, rd_we & ~ale, pc}.
- Reset mid-request: valid, state and data_req_o clear immediately (asynchronously). A request outstanding at that point is abandoned; mem1 sees no instruction.
- addr_ok while data_req_o is low is ignored.

Test Plan:
- ALU pass-through: ex bus with mem_ctl=0, exe_result=0x1234, rd=5, we=1, ctl_ex_over_i=1, mem1_allowin=1 -> next cycle over=1, no req, bus exe_result=0x1234, dest=5.
- Store byte: addr=0x1003, st=0xAABBCCDD, size=00, addr_ok=1 immediately -> req=1, wr=1, wstrb=1000, wdata=0xDDDDDDDD, over in the same cycle.
- Load word with addr_ok delayed 3 cycles -> req held 4 cycles with a stable address, ex stalled (allowin=0), over only in the fourth cycle, exactly one accepted request.
- Half load at 0x2001 -> ale_o=1, req never asserted, forwarded rd_we=0, over in 1 cycle.
- Handshake done while mem1_allowin=0 for 2 cycles -> enter DONE, req low, over held high, instruction leaves on the cycle mem1_allowin rises.
- rst_ni pulled low while in WAIT -> req, valid and over drop asynchronously; after release, allowin=1, state IDLE.
